// File: rtl/axi_slave_req_pop_arbiter.sv
// Pop-side scheduler: drains AW/W and AR request FIFOs, arbitrates write vs read, and
// presents one header (then any write burst) downstream. Optional AXI_POP_ARB_WR_PRIORITY_EN.
module axi_slave_req_pop_arbiter #(
  parameter int unsigned AW_ENTRY_WIDTH = 91,
  parameter int unsigned AR_ENTRY_WIDTH = 75,
  parameter int unsigned HDR_WIDTH      = 91,
  parameter int unsigned DATA_WIDTH     = 1024,
  parameter int unsigned LEN_LSB        = 24
`ifdef AXI_POP_ARB_WR_PRIORITY_EN
  ,
  parameter int unsigned STARVE_LIMIT   = 4
`endif
) (
  input  logic                      axi_clk,
  input  logic                      ARESTn,
  input  logic                      aw_empty,
  input  logic [AW_ENTRY_WIDTH-1:0] aw_rd_data,
  output logic                      aw_rd_en,
  input  logic                      w_empty,
  input  logic [DATA_WIDTH-1:0]     w_rd_data,
  output logic                      w_rd_en,
  input  logic                      ar_empty,
  input  logic [AR_ENTRY_WIDTH-1:0] ar_rd_data,
  output logic                      ar_rd_en,
  output logic                      hdr_valid,
  input  logic                      hdr_ready,
  output logic                      hdr_is_write,
  output logic [HDR_WIDTH-1:0]      hdr_data,
  output logic                      dat_valid,
  input  logic                      dat_ready,
  output logic [DATA_WIDTH-1:0]     dat_data,
  output logic                      dat_last
);

  localparam int unsigned LEN_W = 8;
  localparam int unsigned CNT_W = LEN_W + 1;

  typedef enum logic [1:0] {ARB_IDLE, WR_HDR, RD_HDR, WR_DATA} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             grant_wr_c;

`ifdef AXI_POP_ARB_WR_PRIORITY_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;

  // Write wins unless it has already won STARVE_LIMIT contended rounds in a row.
  always_comb begin
    grant_wr_c = !aw_empty && (ar_empty || (starve_q < STARVE_W'(STARVE_LIMIT)));
    starve_d   = starve_q;
    if (state_q == ARB_IDLE) begin
      if (!aw_empty && !ar_empty && grant_wr_c) begin
        starve_d = starve_q + STARVE_W'(1);
      end else if (!ar_empty && !grant_wr_c) begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge ARESTn) begin
    if (!ARESTn) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`else
  logic last_wr_q, last_wr_d;

  // Round-robin: on contention grant the type not served last.
  always_comb begin
    grant_wr_c = !aw_empty && (ar_empty || !last_wr_q);
    last_wr_d  = last_wr_q;
    if ((state_q == WR_HDR) && hdr_ready) last_wr_d = 1'b1;
    if ((state_q == RD_HDR) && hdr_ready) last_wr_d = 1'b0;
  end

  always_ff @(posedge axi_clk or negedge ARESTn) begin
    if (!ARESTn) last_wr_q <= 1'b0;
    else         last_wr_q <= last_wr_d;
  end
`endif

  always_ff @(posedge axi_clk or negedge ARESTn) begin
    if (!ARESTn) begin
      state_q    <= ARB_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next state plus outputs, decoded straight from state and FIFO heads.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    aw_rd_en     = 1'b0;
    ar_rd_en     = 1'b0;
    w_rd_en      = 1'b0;
    hdr_valid    = 1'b0;
    hdr_is_write = 1'b0;
    hdr_data     = '0;
    dat_valid    = 1'b0;
    dat_data     = '0;
    dat_last     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (!aw_empty || !ar_empty) state_d = grant_wr_c ? WR_HDR : RD_HDR;
      end
      WR_HDR: begin
        hdr_valid    = 1'b1;
        hdr_is_write = 1'b1;
        hdr_data     = HDR_WIDTH'(aw_rd_data);
        if (hdr_ready) begin
          aw_rd_en   = 1'b1;
          beat_cnt_d = CNT_W'(aw_rd_data[LEN_LSB +: LEN_W]);
          state_d    = WR_DATA;
        end
      end
      RD_HDR: begin
        hdr_valid = 1'b1;
        hdr_data  = HDR_WIDTH'(ar_rd_data);
        if (hdr_ready) begin
          ar_rd_en = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      WR_DATA: begin
        // An empty W FIFO here is a producer bug; stall rather than pop garbage.
        dat_valid = !w_empty;
        dat_data  = w_rd_data;
        dat_last  = (beat_cnt_q == '0);
        if (!w_empty && dat_ready) begin
          w_rd_en = 1'b1;
          if (beat_cnt_q == '0) state_d    = ARB_IDLE;
          else                  beat_cnt_d = beat_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_slave_req_pop_arbiter.sv
// Directed bench for axi_slave_req_pop_arbiter with FIFO models and a header/beat scoreboard.
module tb_axi_slave_req_pop_arbiter;

  localparam int unsigned AWW = 91;
  localparam int unsigned ARW = 75;
  localparam int unsigned HW  = 91;
  localparam int unsigned DW  = 1024;
  localparam int unsigned LSB = 24;

  logic           axi_clk = 1'b0;
  logic           ARESTn;
  logic           aw_empty, w_empty, ar_empty;
  logic [AWW-1:0] aw_rd_data;
  logic [DW-1:0]  w_rd_data;
  logic [ARW-1:0] ar_rd_data;
  logic           aw_rd_en, w_rd_en, ar_rd_en;
  logic           hdr_valid, hdr_ready, hdr_is_write;
  logic [HW-1:0]  hdr_data;
  logic           dat_valid, dat_ready, dat_last;
  logic [DW-1:0]  dat_data;

  always #5 axi_clk = ~axi_clk;

  axi_slave_req_pop_arbiter #(
    .LEN_LSB(LSB)
`ifdef AXI_POP_ARB_WR_PRIORITY_EN
    , .STARVE_LIMIT(2)
`endif
  ) dut (
    .axi_clk(axi_clk), .ARESTn(ARESTn),
    .aw_empty(aw_empty), .aw_rd_data(aw_rd_data), .aw_rd_en(aw_rd_en),
    .w_empty(w_empty), .w_rd_data(w_rd_data), .w_rd_en(w_rd_en),
    .ar_empty(ar_empty), .ar_rd_data(ar_rd_data), .ar_rd_en(ar_rd_en),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_is_write(hdr_is_write),
    .hdr_data(hdr_data), .dat_valid(dat_valid), .dat_ready(dat_ready),
    .dat_data(dat_data), .dat_last(dat_last)
  );

  typedef struct packed { logic is_wr; logic [HW-1:0] data; } hdr_exp_t;
  typedef struct packed { logic last;  logic [DW-1:0] data; } dat_exp_t;

  logic [AWW-1:0] aw_q[$];
  logic [ARW-1:0] ar_q[$];
  logic [DW-1:0]  w_q[$];
  hdr_exp_t       exp_hdr[$];
  dat_exp_t       exp_dat[$];

  int checks   = 0;
  int failures = 0;
  int w_pops   = 0;

  logic          s_hdr_valid, s_hdr_is_write, s_dat_valid, s_dat_last;
  logic          s_aw_en, s_ar_en, s_w_en;
  logic [HW-1:0] s_hdr_data;
  logic [DW-1:0] s_dat_data;
  logic          prev_hold = 1'b0;
  logic          prev_is_wr;
  logic [HW-1:0] prev_hdr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed[127:0]=%0h expected[127:0]=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic drive_fifos();
    aw_empty = (aw_q.size() == 0);
    ar_empty = (ar_q.size() == 0);
    w_empty  = (w_q.size() == 0);
    aw_rd_data = '0;
    ar_rd_data = '0;
    w_rd_data  = '0;
    if (!aw_empty) aw_rd_data = aw_q[0];
    if (!ar_empty) ar_rd_data = ar_q[0];
    if (!w_empty)  w_rd_data  = w_q[0];
  endtask

  // Store a full W burst first, then its AW entry, as the push side does.
  task automatic push_aw(input int unsigned len);
    logic [AWW-1:0] e;
    logic [DW-1:0]  b;
    e = AWW'({$urandom, $urandom, $urandom});
    e[LSB +: 8] = 8'(len);
    for (int i = 0; i <= int'(len); i++) begin
      for (int k = 0; k < int'(DW / 32); k++) b[k*32 +: 32] = $urandom;
      w_q.push_back(b);
      exp_dat.push_back('{last: (i == int'(len)), data: b});
    end
    aw_q.push_back(e);
    exp_hdr.push_back('{is_wr: 1'b1, data: HW'(e)});
    drive_fifos();
  endtask

  task automatic push_ar();
    logic [ARW-1:0] e;
    e = ARW'({$urandom, $urandom, $urandom});
    ar_q.push_back(e);
    exp_hdr.push_back('{is_wr: 1'b0, data: HW'(e)});
    drive_fifos();
  endtask

  // One clock: sample and score mid-cycle, then apply FIFO pops after the edge.
  task automatic step();
    hdr_exp_t h;
    dat_exp_t d;
    @(negedge axi_clk);
    s_hdr_valid = hdr_valid; s_hdr_is_write = hdr_is_write; s_hdr_data = hdr_data;
    s_dat_valid = dat_valid; s_dat_last = dat_last; s_dat_data = dat_data;
    s_aw_en = aw_rd_en; s_ar_en = ar_rd_en; s_w_en = w_rd_en;
    check("pop_onehot", ($countones({s_aw_en, s_ar_en, s_w_en}) <= 1), 1);
    check("pop_when_empty", (s_aw_en && aw_empty) || (s_ar_en && ar_empty) || (s_w_en && w_empty), 0);
    check("pop_without_handshake",
          (s_aw_en && !(s_hdr_valid && hdr_ready && s_hdr_is_write)) ||
          (s_ar_en && !(s_hdr_valid && hdr_ready && !s_hdr_is_write)) ||
          (s_w_en && !(s_dat_valid && dat_ready)), 0);
    if (prev_hold)
      check("hdr_hold", {s_hdr_valid, s_hdr_is_write, s_hdr_data}, {1'b1, prev_is_wr, prev_hdr});
    prev_hold = s_hdr_valid && !hdr_ready;
    prev_is_wr = s_hdr_is_write;
    prev_hdr = s_hdr_data;
    if (s_hdr_valid && hdr_ready) begin
      check("hdr_expected", (exp_hdr.size() != 0), 1);
      if (exp_hdr.size() != 0) begin
        h = exp_hdr.pop_front();
        check("hdr_is_write", s_hdr_is_write, h.is_wr);
        check("hdr_data", s_hdr_data, h.data);
        check("hdr_pop", h.is_wr ? s_aw_en : s_ar_en, 1);
      end
    end
    if (s_dat_valid && dat_ready) begin
      check("dat_expected", (exp_dat.size() != 0), 1);
      if (exp_dat.size() != 0) begin
        d = exp_dat.pop_front();
        check("dat_last", s_dat_last, d.last);
        check_data("dat_data", s_dat_data, d.data);
      end
    end
    if (s_w_en) w_pops++;
    @(posedge axi_clk);
    #1;
    if (s_aw_en && aw_q.size() != 0) void'(aw_q.pop_front());
    if (s_ar_en && ar_q.size() != 0) void'(ar_q.pop_front());
    if (s_w_en  && w_q.size()  != 0) void'(w_q.pop_front());
    drive_fifos();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((exp_hdr.size() != 0 || exp_dat.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    check({tag, "_drained"}, exp_hdr.size() + exp_dat.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {aw_rd_en, ar_rd_en, w_rd_en, hdr_valid, hdr_is_write, dat_valid, dat_last}, 0);
    check({tag, "_hdr_data"}, hdr_data, 0);
    check_data({tag, "_dat_data"}, dat_data, '0);
  endtask

  initial begin
    int n;
    ARESTn = 1'b0; hdr_ready = 1'b1; dat_ready = 1'b1;
    drive_fifos();
    repeat (2) @(posedge axi_clk);
    #1;
    check_all_zero("reset");
    ARESTn = 1'b1;

    // Write-only AWLEN=3 latency profile
    push_aw(3);
    step(); check("t1_c0_hdr_valid", s_hdr_valid, 0);
    step(); check("t1_c1_hdr_valid", s_hdr_valid, 1); check("t1_c1_aw_pop", s_aw_en, 1);
    for (int k = 2; k <= 5; k++) begin
      step();
      check("t1_beat_valid", s_dat_valid, 1);
      check("t1_beat_last", s_dat_last, (k == 5));
    end
    step(); check("t1_c6_idle", {s_hdr_valid, s_dat_valid, s_aw_en, s_w_en}, 0);

    // Contention from reset; push order equals expected grant order
    ARESTn = 1'b0; prev_hold = 1'b0;
`ifdef AXI_POP_ARB_WR_PRIORITY_EN
    push_aw(0); push_aw(1); push_ar();
`else
    push_aw(0); push_ar(); push_aw(1);
`endif
    @(posedge axi_clk); #1; ARESTn = 1'b1;
    drain("t2", 40);

    // Header backpressure
    hdr_ready = 1'b0;
    push_ar();
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_hdr_valid_held", s_hdr_valid, 1);
      check("t3_no_pop", {s_ar_en, s_aw_en}, 0);
      check("t3_hdr_data", s_hdr_data, exp_hdr[0].data);
    end
    hdr_ready = 1'b1;
    step(); check("t3_pop_on_ready", s_ar_en, 1);
    drain("t3", 10);

    // Toggling dat_ready across an AWLEN=7 burst
    w_pops = 0; dat_ready = 1'b0;
    push_aw(7);
    n = 0;
    while (exp_dat.size() != 0 && n < 60) begin
      step();
      dat_ready = ~dat_ready;
      n++;
    end
    dat_ready = 1'b1;
    check("t4_w_pops", w_pops, 8);
    drain("t4", 10);

    // Reset during beat 3 of 4; second AW must be re-arbitrated
    w_pops = 0;
    push_aw(3); push_aw(0);
    n = 0;
    while (w_pops < 2 && n < 20) begin step(); n++; end
    check("t5_two_beats", w_pops, 2);
    check("t5_pre_reset_valid", dat_valid, 1);
    ARESTn = 1'b0; prev_hold = 1'b0;
    #1;
    check_all_zero("t5_reset");
    for (int k = 0; k < 2; k++) begin
      void'(w_q.pop_front());
      void'(exp_dat.pop_front());
    end
    drive_fifos();
    step();
    ARESTn = 1'b1;
    step(); check("t5_idle_after_reset", s_hdr_valid, 0);
    step(); check("t5_rearb_write_hdr", {s_hdr_valid, s_hdr_is_write}, 2'b11);
    drain("t5", 20);

`ifdef AXI_POP_ARB_WR_PRIORITY_EN
    // Starvation limit 2: six writes, one read
    ARESTn = 1'b0; prev_hold = 1'b0;
    push_aw(0); push_aw(1); push_ar();
    for (int k = 0; k < 4; k++) push_aw(k % 2);
    @(posedge axi_clk); #1; ARESTn = 1'b1;
    drain("t6", 80);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
